// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Shares one single-port data memory between the processor and an I/O
// requester (game/peripheral logic). The processor normally wins, but an I/O
// request that has lost STARVE_LIMIT consecutive cycles is forced in for one
// cycle while the processor is stalled.
//
// Parameters:
//   ADDR_W       - dmem word-address width
//   DATA_W       - dmem data width
//   STARVE_LIMIT - consecutive lost cycles before the I/O port is forced in (1..255)
//
// Ports:
//   clock, reset                 - single clock, synchronous active-low reset
//   proc_access/addr/wdata/wren  - processor load/store request
//   proc_rdata, proc_stall       - processor load data and stall
//   io_req/addr/wdata/we         - I/O request (held until io_gnt)
//   io_gnt, io_rvalid, io_rdata  - I/O grant, read-data valid and read data
//   mem_addr/wdata/wren, mem_q   - dmem port
module dmem_arbiter #(
   parameter int ADDR_W       = 12,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              proc_access,
   input  logic [ADDR_W-1:0] proc_addr,
   input  logic [DATA_W-1:0] proc_wdata,
   input  logic              proc_wren,
   output logic [DATA_W-1:0] proc_rdata,
   output logic              proc_stall,
   input  logic              io_req,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [DATA_W-1:0] io_wdata,
   input  logic              io_we,
   output logic              io_gnt,
   output logic              io_rvalid,
   output logic [DATA_W-1:0] io_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q
);

   typedef enum logic {
      IDLE  = 1'b0,
      FORCE = 1'b1
   } state_t;

   localparam logic [8:0] LIMIT = 9'(STARVE_LIMIT);

   state_t     state;
   state_t     state_next;
   logic [7:0] wait_cnt;
   logic [7:0] wait_cnt_next;
   logic [8:0] wait_inc;
   logic       owner_io;

   // The memory returns data one cycle after the address, so both readers
   // simply see mem_q; validity is signalled separately.
   assign proc_rdata = mem_q;
   assign io_rdata   = mem_q;

   // Ownership, memory mux, grant/stall and next-state logic.
   // While reset is low everything falls back to the processor path with
   // writes suppressed. In FORCE the I/O side owns the memory even if the
   // requester withdrew, so the write enable is also qualified by io_req
   // to keep a dropped request from writing anything.
   always_comb begin
      owner_io      = 1'b0;
      io_gnt        = 1'b0;
      proc_stall    = 1'b0;
      mem_addr      = proc_addr;
      mem_wdata     = proc_wdata;
      mem_wren      = proc_wren & proc_access;
      state_next    = state;
      wait_cnt_next = wait_cnt;
      wait_inc      = {1'b0, wait_cnt} + 9'd1;

      if (!reset) begin
         mem_wren      = 1'b0;
         state_next    = IDLE;
         wait_cnt_next = 8'd0;
      end else begin
         owner_io   = (state == FORCE) || ((state == IDLE) && io_req && !proc_access);
         proc_stall = (state == FORCE);
         io_gnt     = owner_io & io_req;

         if (owner_io) begin
            mem_addr  = io_addr;
            mem_wdata = io_wdata;
            mem_wren  = io_we & io_req;
         end

         // Counts consecutive cycles the pending request has lost.
         if (io_req && !io_gnt) begin
            wait_cnt_next = (wait_cnt == 8'hFF) ? 8'hFF : wait_cnt + 8'd1;
         end else begin
            wait_cnt_next = 8'd0;
         end

         case (state)
            IDLE: begin
               if (io_req && !io_gnt && (wait_inc >= LIMIT)) begin
                  state_next = FORCE;
               end
            end
            FORCE: begin
               state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // State register, starvation counter and the one-cycle read-valid pulse
   // that follows every I/O read grant.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         wait_cnt  <= 8'd0;
         io_rvalid <= 1'b0;
      end else begin
         state     <= state_next;
         wait_cnt  <= wait_cnt_next;
         io_rvalid <= io_gnt & ~io_we;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter: a table of single-cycle vectors for
// the basic arbitration cases, followed by hand-written multi-cycle
// sequences for starvation, reset during FORCE/after a read grant, and a
// request withdrawn during FORCE. A simple synchronous memory stands in
// for dmem, preloaded with 0xA000_0000 | address.
module tb_dmem_arbiter;

   logic        clock;
   logic        reset;
   logic        proc_access;
   logic [11:0] proc_addr;
   logic [31:0] proc_wdata;
   logic        proc_wren;
   logic [31:0] proc_rdata;
   logic        proc_stall;
   logic        io_req;
   logic [11:0] io_addr;
   logic [31:0] io_wdata;
   logic        io_we;
   logic        io_gnt;
   logic        io_rvalid;
   logic [31:0] io_rdata;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_wren;
   logic [31:0] mem_q;

   int assert_count = 0;
   int fail_count   = 0;

   typedef struct {
      logic        rst;
      logic        pa;
      logic [11:0] pad;
      logic [31:0] pwd;
      logic        pwe;
      logic        ir;
      logic [11:0] iad;
      logic [31:0] iwd;
      logic        iwe;
      logic        e_gnt;
      logic        e_stall;
      logic [11:0] e_addr;
      logic        e_wren;
      logic        e_rvalid;
      logic [7:0]  e_wait;
      logic        chk_q;
      logic [31:0] e_q;
   } vec_t;

   vec_t vecs [12];

   dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .STARVE_LIMIT(8)) dut (
      .clock       (clock),
      .reset       (reset),
      .proc_access (proc_access),
      .proc_addr   (proc_addr),
      .proc_wdata  (proc_wdata),
      .proc_wren   (proc_wren),
      .proc_rdata  (proc_rdata),
      .proc_stall  (proc_stall),
      .io_req      (io_req),
      .io_addr     (io_addr),
      .io_wdata    (io_wdata),
      .io_we       (io_we),
      .io_gnt      (io_gnt),
      .io_rvalid   (io_rvalid),
      .io_rdata    (io_rdata),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q)
   );

   // Free-running clock, 10 time units per cycle.
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Synchronous single-port memory: registered read, old data on a
   // read-during-write. Contents are preloaded on the first edge.
   logic [31:0] mem [4096];
   bit          mem_init = 1'b0;
   always @(posedge clock) begin
      if (!mem_init) begin
         for (int i = 0; i < 4096; i++) begin
            mem[i] <= 32'hA000_0000 | 32'(i);
         end
         mem_init <= 1'b1;
      end else begin
         if (mem_wren) begin
            mem[mem_addr] <= mem_wdata;
         end
         mem_q <= mem[mem_addr];
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      assert_count++;
      if (actual !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Waits for the next rising edge, then drives a new set of inputs just
   // after it and lets them settle until the middle of the cycle.
   task automatic applyStimulus(input logic rst, input logic pa, input logic [11:0] pad,
                                input logic [31:0] pwd, input logic pwe, input logic ir,
                                input logic [11:0] iad, input logic [31:0] iwd, input logic iwe);
      @(posedge clock);
      #1;
      reset       = rst;
      proc_access = pa;
      proc_addr   = pad;
      proc_wdata  = pwd;
      proc_wren   = pwe;
      io_req      = ir;
      io_addr     = iad;
      io_wdata    = iwd;
      io_we       = iwe;
      #4;
   endtask

   // Eight cycles of a continuously busy processor against a held I/O
   // request: the request must lose every one of them.
   task automatic runStarve(input logic [11:0] iad, input logic iwe);
      for (int k = 1; k <= 8; k++) begin
         applyStimulus(1'b1, 1'b1, 12'h100, 32'h5555_0100, 1'b1, 1'b1, iad, 32'hBEEF_0000, iwe);
         checkOutput($sformatf("starve_gnt_c%0d", k), 32'(io_gnt), 32'd0);
         checkOutput($sformatf("starve_stall_c%0d", k), 32'(proc_stall), 32'd0);
         checkOutput($sformatf("starve_addr_c%0d", k), 32'(mem_addr), 32'h100);
      end
   endtask

   initial begin
      reset       = 1'b0;
      proc_access = 1'b0;
      proc_addr   = 12'h0;
      proc_wdata  = 32'h0;
      proc_wren   = 1'b0;
      io_req      = 1'b0;
      io_addr     = 12'h0;
      io_wdata    = 32'h0;
      io_we       = 1'b0;

      //          rst   pa    pad     pwd           pwe   ir    iad     iwd           iwe   gnt   stall addr    wren  rvalid wait   chk_q e_q
      vecs[0]  = '{1'b0, 1'b0, 12'h011, 32'h0,        1'b0, 1'b1, 12'h055, 32'hDEAD_0055, 1'b1, 1'b0, 1'b0, 12'h011, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0};
      vecs[1]  = '{1'b0, 1'b0, 12'h011, 32'h0,        1'b0, 1'b1, 12'h055, 32'hDEAD_0055, 1'b1, 1'b0, 1'b0, 12'h011, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0};
      vecs[2]  = '{1'b1, 1'b0, 12'h011, 32'h0,        1'b0, 1'b1, 12'h010, 32'h0,         1'b0, 1'b1, 1'b0, 12'h010, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0};
      vecs[3]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h010, 32'h0,         1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1, 8'd0, 1'b1, 32'hA000_0010};
      vecs[4]  = '{1'b1, 1'b1, 12'h020, 32'h1234_5678, 1'b1, 1'b1, 12'h030, 32'hCAFE_0030, 1'b1, 1'b0, 1'b0, 12'h020, 1'b1, 1'b0, 8'd0, 1'b0, 32'h0};
      vecs[5]  = '{1'b1, 1'b0, 12'h020, 32'h1234_5678, 1'b1, 1'b1, 12'h030, 32'hCAFE_0030, 1'b1, 1'b1, 1'b0, 12'h030, 1'b1, 1'b0, 8'd1, 1'b0, 32'h0};
      vecs[6]  = '{1'b1, 1'b1, 12'h020, 32'h0,        1'b0, 1'b0, 12'h030, 32'h0,         1'b0, 1'b0, 1'b0, 12'h020, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0};
      vecs[7]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 12'h001, 32'h0,         1'b0, 1'b1, 1'b0, 12'h001, 1'b0, 1'b0, 8'd0, 1'b1, 32'h1234_5678};
      vecs[8]  = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b1, 12'h002, 32'h0,         1'b0, 1'b1, 1'b0, 12'h002, 1'b0, 1'b1, 8'd0, 1'b1, 32'hA000_0001};
      vecs[9]  = '{1'b1, 1'b0, 12'h030, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,         1'b0, 1'b0, 1'b0, 12'h030, 1'b0, 1'b1, 8'd0, 1'b1, 32'hA000_0002};
      vecs[10] = '{1'b1, 1'b1, 12'h030, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,         1'b0, 1'b0, 1'b0, 12'h030, 1'b0, 1'b0, 8'd0, 1'b0, 32'h0};
      vecs[11] = '{1'b1, 1'b0, 12'h000, 32'h0,        1'b0, 1'b0, 12'h000, 32'h0,         1'b0, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 8'd0, 1'b1, 32'hCAFE_0030};

      // Two idle reset cycles so the memory model is loaded before use.
      applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);

      $display("[TB] Vector table");
      for (int i = 0; i < 12; i++) begin
         applyStimulus(vecs[i].rst, vecs[i].pa, vecs[i].pad, vecs[i].pwd, vecs[i].pwe,
                       vecs[i].ir, vecs[i].iad, vecs[i].iwd, vecs[i].iwe);
         checkOutput($sformatf("v%0d_gnt", i), 32'(io_gnt), 32'(vecs[i].e_gnt));
         checkOutput($sformatf("v%0d_stall", i), 32'(proc_stall), 32'(vecs[i].e_stall));
         checkOutput($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
         checkOutput($sformatf("v%0d_wren", i), 32'(mem_wren), 32'(vecs[i].e_wren));
         checkOutput($sformatf("v%0d_rvalid", i), 32'(io_rvalid), 32'(vecs[i].e_rvalid));
         checkOutput($sformatf("v%0d_wait", i), 32'(dut.wait_cnt), 32'(vecs[i].e_wait));
         if (vecs[i].chk_q) begin
            checkOutput($sformatf("v%0d_io_rdata", i), io_rdata, vecs[i].e_q);
            checkOutput($sformatf("v%0d_proc_rdata", i), proc_rdata, vecs[i].e_q);
         end
      end

      $display("[TB] Starvation: forced grant in the 9th cycle");
      runStarve(12'h200, 1'b0);
      applyStimulus(1'b1, 1'b1, 12'h100, 32'h5555_0100, 1'b1, 1'b1, 12'h200, 32'hBEEF_0000, 1'b0);
      checkOutput("force_gnt", 32'(io_gnt), 32'd1);
      checkOutput("force_stall", 32'(proc_stall), 32'd1);
      checkOutput("force_addr", 32'(mem_addr), 32'h200);
      checkOutput("force_wren", 32'(mem_wren), 32'd0);
      checkOutput("force_wait", 32'(dut.wait_cnt), 32'd8);
      applyStimulus(1'b1, 1'b1, 12'h100, 32'h5555_0100, 1'b1, 1'b0, 12'h000, 32'h0, 1'b0);
      checkOutput("after_force_stall", 32'(proc_stall), 32'd0);
      checkOutput("after_force_gnt", 32'(io_gnt), 32'd0);
      checkOutput("after_force_addr", 32'(mem_addr), 32'h100);
      checkOutput("after_force_wren", 32'(mem_wren), 32'd1);
      checkOutput("after_force_rvalid", 32'(io_rvalid), 32'd1);
      checkOutput("after_force_rdata", io_rdata, 32'hA000_0200);
      checkOutput("after_force_wait", 32'(dut.wait_cnt), 32'd0);

      $display("[TB] Reset during FORCE");
      applyStimulus(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      runStarve(12'h210, 1'b0);
      applyStimulus(1'b0, 1'b1, 12'h100, 32'h5555_0100, 1'b1, 1'b1, 12'h210, 32'hBEEF_0000, 1'b0);
      checkOutput("rstforce_stall", 32'(proc_stall), 32'd0);
      checkOutput("rstforce_gnt", 32'(io_gnt), 32'd0);
      checkOutput("rstforce_wren", 32'(mem_wren), 32'd0);
      checkOutput("rstforce_addr", 32'(mem_addr), 32'h100);
      applyStimulus(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      checkOutput("rstforce_state", 32'(dut.state), 32'd0);
      checkOutput("rstforce_wait", 32'(dut.wait_cnt), 32'd0);
      checkOutput("rstforce_rvalid", 32'(io_rvalid), 32'd0);
      applyStimulus(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      checkOutput("rstforce_rvalid2", 32'(io_rvalid), 32'd0);

      $display("[TB] Reset in the cycle after a read grant");
      applyStimulus(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b1, 12'h005, 32'h0, 1'b0);
      checkOutput("rstgrant_gnt", 32'(io_gnt), 32'd1);
      applyStimulus(1'b0, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      applyStimulus(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      checkOutput("rstgrant_rvalid", 32'(io_rvalid), 32'd0);

      $display("[TB] Request withdrawn during FORCE");
      runStarve(12'h300, 1'b1);
      applyStimulus(1'b1, 1'b1, 12'h100, 32'h5555_0100, 1'b1, 1'b0, 12'h300, 32'hBEEF_0000, 1'b1);
      checkOutput("drop_gnt", 32'(io_gnt), 32'd0);
      checkOutput("drop_wren", 32'(mem_wren), 32'd0);
      checkOutput("drop_stall", 32'(proc_stall), 32'd1);
      applyStimulus(1'b1, 1'b0, 12'h300, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      checkOutput("drop_state", 32'(dut.state), 32'd0);
      checkOutput("drop_rvalid", 32'(io_rvalid), 32'd0);
      checkOutput("drop_wait", 32'(dut.wait_cnt), 32'd0);
      applyStimulus(1'b1, 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 12'h0, 32'h0, 1'b0);
      checkOutput("drop_nowrite", proc_rdata, 32'hA000_0300);

      $display("[TB] End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule
